// File: rtl/count_bcd_display_pkg.sv
// count_disp_pkg: shared constants, FSM state type and BCD digit helper for the display path
package count_disp_pkg;
    localparam int NDIG = 3;
    typedef enum logic {IDLE, SHIFT} state_t;
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction
endpackage

// File: rtl/count_bcd_display_if.sv
// count_bcd_display_if: conversion request/result and display pins between counter logic and the display block
interface count_bcd_display_if #(parameter int IN_W = 7);
    import count_disp_pkg::*;
    logic [IN_W-1:0]   value;
    logic              load;
    logic              busy;
    logic [4*NDIG-1:0] bcd;
    logic              bcd_valid;
    logic [NDIG-1:0]   an;
    logic [6:0]        seg;
    modport master (output value, load, input busy, bcd, bcd_valid, an, seg);
    modport slave  (input value, load, output busy, bcd, bcd_valid, an, seg);
endinterface

// File: rtl/count_bcd_display_seg7_decoder.sv
// seg7_decoder: BCD digit to active-high {g,f,e,d,c,b,a} segments, with forced blanking
module seg7_decoder
    import count_disp_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);
    // Digits 10..15 cannot occur from the converter, so they simply go dark
    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (digit_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end
endmodule

// File: rtl/count_bcd_display.sv
// count_bcd_display: sequential double-dabble binary-to-BCD with a multiplexed 3-digit seven-segment scan
module count_bcd_display
    import count_disp_pkg::*;
#(
    parameter int IN_W        = 7,
    parameter int REFRESH_DIV = 4,
    parameter int BLANK_LZ    = 1
) (
    input  logic          clk,
    input  logic          reset,
    count_bcd_display_if.slave bus
);
    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    state_t            state_q, state_d;
    logic [IN_W-1:0]   shreg_q, shreg_d;
    logic [4*NDIG-1:0] scratch_q, scratch_d, adj;
    logic [3:0]        step_q, step_d;
    logic [4*NDIG-1:0] bcd_q, bcd_d;
    logic              valid_q, valid_d;
    logic [DIV_W-1:0]  div_q;
    logic [1:0]        idx_q;
    logic [3:0]        digit;
    logic              blank;

    // Conversion control: capture in IDLE, one add-3/shift per clock in SHIFT, publish on the last step
    always_comb begin
        adj       = {add3(scratch_q[11:8]), add3(scratch_q[7:4]), add3(scratch_q[3:0])};
        state_d   = state_q;
        shreg_d   = shreg_q;
        scratch_d = scratch_q;
        step_d    = step_q;
        bcd_d     = bcd_q;
        valid_d   = 1'b0;
        case (state_q)
            IDLE: if (bus.load) begin
                shreg_d   = bus.value;
                scratch_d = '0;
                step_d    = '0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                {scratch_d, shreg_d} = {adj, shreg_q} << 1;
                step_d               = step_q + 4'd1;
                if (step_q == 4'(IN_W - 1)) begin
                    bcd_d   = scratch_d;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Converter state registers; reset abandons any conversion in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            scratch_q <= '0;
            step_q    <= '0;
            bcd_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            scratch_q <= scratch_d;
            step_q    <= step_d;
            bcd_q     <= bcd_d;
            valid_q   <= valid_d;
        end
    end

    // Scan timing: each digit stays lit REFRESH_DIV clocks, independent of conversion activity
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
            idx_q <= '0;
        end else if (div_q == DIV_W'(REFRESH_DIV - 1)) begin
            div_q <= '0;
            idx_q <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    assign digit = (idx_q == 2'd2) ? bcd_q[11:8] : (idx_q == 2'd1) ? bcd_q[7:4] : bcd_q[3:0];
    assign blank = (BLANK_LZ != 0) &&
                   (((idx_q == 2'd2) && (bcd_q[11:8] == 4'd0)) ||
                    ((idx_q == 2'd1) && (bcd_q[11:4] == 8'd0)));

    seg7_decoder u_dec (
        .digit_i (digit),
        .blank_i (blank),
        .seg_o   (bus.seg)
    );

    assign bus.busy      = (state_q == SHIFT);
    assign bus.bcd       = bcd_q;
    assign bus.bcd_valid = valid_q;
    assign bus.an        = 3'b001 << idx_q;
endmodule

// File: tb/tb_count_bcd_display.sv
// tb_count_bcd_display: scoreboard bench for BCD conversion, blanking and digit scan
module tb_count_bcd_display;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_checks = 0;
    int n_fail = 0;
    int pulses = 0;
    logic [11:0] exp_q[$];

    count_bcd_display_if #(.IN_W(7)) bus ();

    count_bcd_display #(.IN_W(7), .REFRESH_DIV(4), .BLANK_LZ(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Advance to next falling edge; any bcd_valid pulse is matched against the scoreboard
    task automatic tick();
        logic [11:0] e;
        @(negedge clk);
        if (bus.bcd_valid === 1'b1) begin
            pulses++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid got bcd=%h required no pulse", bus.bcd);
            end else begin
                e = exp_q.pop_front();
                if (bus.bcd !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard_bcd got %h required %h", bus.bcd, e);
                end
            end
        end
    endtask

    task automatic do_load(input int v, input bit push);
        bus.value = 7'(v);
        bus.load = 1'b1;
        if (push) exp_q.push_back(to_bcd(v));
        tick();
        bus.load = 1'b0;
    endtask

    task automatic wait_valid(input int max, output int lat);
        int p0;
        p0 = pulses;
        lat = 0;
        while (pulses == p0 && lat < max) begin
            tick();
            lat++;
        end
        n_checks++;
        if (pulses == p0) begin
            n_fail++;
            $display("FAIL valid_timeout got no pulse in %0d cycles required one", max);
        end
    endtask

    task automatic check_digit(input logic [2:0] an_t, input logic [6:0] seg_e, input string name);
        int k;
        k = 0;
        while (bus.an !== an_t && k < 16) begin
            tick();
            k++;
        end
        n_checks++;
        if (bus.an !== an_t || bus.seg !== seg_e) begin
            n_fail++;
            $display("FAIL %s got an=%b seg=%b required an=%b seg=%b", name, bus.an, bus.seg, an_t, seg_e);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.bcd !== 12'h000 || bus.bcd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got busy=%b bcd=%h valid=%b required 0 000 0", bus.busy, bus.bcd, bus.bcd_valid);
        end
        n_checks++;
        if (bus.an !== 3'b001 || bus.seg !== 7'b0111111) begin
            n_fail++;
            $display("FAIL reset_display got an=%b seg=%b required 001 0111111", bus.an, bus.seg);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_zero();
        int lat;
        do_load(0, 1'b1);
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_load got %b required 1", bus.busy);
        end
        wait_valid(20, lat);
        n_checks++;
        if (lat != 7) begin
            n_fail++;
            $display("FAIL latency got %0d cycles after load edge required 7", lat);
        end
        tick();
        n_checks++;
        if (bus.bcd_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_one_cycle got valid=%b busy=%b required 0 0", bus.bcd_valid, bus.busy);
        end
        check_digit(3'b001, 7'b0111111, "zero_units");
        check_digit(3'b010, 7'b0000000, "zero_tens_blank");
        check_digit(3'b100, 7'b0000000, "zero_hund_blank");
    endtask

    task automatic test_127();
        int lat;
        do_load(127, 1'b1);
        wait_valid(20, lat);
        check_digit(3'b001, 7'b0000111, "d127_units");
        check_digit(3'b010, 7'b1011011, "d127_tens");
        check_digit(3'b100, 7'b0000110, "d127_hund");
    endtask

    task automatic test_99();
        int lat;
        do_load(99, 1'b1);
        wait_valid(20, lat);
        check_digit(3'b100, 7'b0000000, "d99_hund_blank");
        check_digit(3'b001, 7'b1101111, "d99_units");
        check_digit(3'b010, 7'b1101111, "d99_tens");
    endtask

    task automatic test_busy_ignore();
        int p0;
        p0 = pulses;
        do_load(45, 1'b1);
        tick();
        bus.value = 7'd100;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_mid_conv got %b required 1", bus.busy);
        end
        repeat (20) tick();
        n_checks++;
        if (pulses - p0 != 1 || bus.bcd !== 12'h045) begin
            n_fail++;
            $display("FAIL busy_ignore got pulses=%0d bcd=%h required 1 045", pulses - p0, bus.bcd);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        do_load(12, 1'b1);
        wait_valid(20, lat);
        do_load(34, 1'b1);
        wait_valid(20, lat);
        n_checks++;
        if (lat != 7 || bus.bcd !== 12'h034) begin
            n_fail++;
            $display("FAIL back_to_back got lat=%0d bcd=%h required 7 034", lat, bus.bcd);
        end
    endtask

    task automatic test_reset_abort();
        int p0, lat;
        do_load(88, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.bcd !== 12'h000 || bus.bcd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_state got busy=%b bcd=%h valid=%b required 0 000 0", bus.busy, bus.bcd, bus.bcd_valid);
        end
        p0 = pulses;
        repeat (12) tick();
        n_checks++;
        if (pulses != p0) begin
            n_fail++;
            $display("FAIL abort_no_valid got %0d pulses required 0", pulses - p0);
        end
        do_load(88, 1'b1);
        wait_valid(20, lat);
        n_checks++;
        if (bus.bcd !== 12'h088) begin
            n_fail++;
            $display("FAIL abort_reload got %h required 088", bus.bcd);
        end
    endtask

    task automatic test_scan();
        logic [2:0] e;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 24; i++) begin
            e = 3'b001 << ((i / 4) % 3);
            n_checks++;
            if (bus.an !== e) begin
                n_fail++;
                $display("FAIL scan_an step %0d got %b required %b", i, bus.an, e);
            end
            if (i == 5) begin
                bus.value = 7'd3;
                bus.load = 1'b1;
                exp_q.push_back(to_bcd(3));
            end else begin
                bus.load = 1'b0;
            end
            tick();
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
        end
    endtask

    initial begin
        bus.value = '0;
        bus.load = 1'b0;
        test_reset();
        test_zero();
        test_127();
        test_99();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        test_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
